// File: rtl/sr_ff_drive_ctrl.sv
// sr_ff_drive_ctrl: handshake front-end that pulses S or R into a clocked SR flip-flop
// and confirms the flip-flop's Q reached the commanded value.
module sr_ff_drive_ctrl #(
  parameter int PULSE_CYC   = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  output logic       cmd_ready,
  input  logic       q_fb,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
  localparam logic [3:0] P_LAST = 4'(PULSE_CYC - 1);
  localparam logic [3:0] T_LAST = 4'(TIMEOUT_CYC - 1);
  state_t     r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic       r_target;
  logic       w_accept, w_pulse_last, w_match, w_timeout;
  logic       w_drive, w_tgt, w_s_nx, w_r_nx, w_busy_nx, w_done_nx, w_err_nx;
  assign cmd_ready    = r_state == IDLE;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_pulse_last = r_cnt == P_LAST;
  assign w_match      = q_fb == r_target;
  assign w_timeout    = r_cnt == T_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_target <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_target <= w_accept ? cmd_op : r_target;
      S        <= w_s_nx;
      R        <= w_r_nx;
      busy     <= w_busy_nx;
      done     <= w_done_nx;
      err      <= w_err_nx;
      err_cnt  <= (w_err_nx && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        w_state_nx = w_accept ? DRIVE : IDLE;
        w_cnt_nx   = w_accept ? 4'd0 : r_cnt;
      end
      DRIVE: begin
        w_state_nx = w_pulse_last ? CHECK : DRIVE;
        w_cnt_nx   = w_pulse_last ? 4'd0 : r_cnt + 4'd1;
      end
      CHECK: begin
        w_state_nx = (w_match || w_timeout) ? IDLE : CHECK;
        w_cnt_nx   = r_cnt + 4'd1;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  // S/R are registered one edge early so the pulse lands in cycles 1..PULSE_CYC after accept
  always_comb begin
    w_drive   = (r_state == IDLE && w_accept) || (r_state == DRIVE && !w_pulse_last);
    w_tgt     = r_state == IDLE ? cmd_op : r_target;
    w_s_nx    = w_drive && w_tgt;
    w_r_nx    = w_drive && !w_tgt;
    w_busy_nx = w_state_nx != IDLE;
    w_done_nx = r_state == CHECK && w_match;
    w_err_nx  = r_state == CHECK && !w_match && w_timeout;
  end
endmodule

// File: tb/tb_sr_ff_drive_ctrl.sv
// tb_sr_ff_drive_ctrl: randomized bench with a timeline-based reference model
// plus directed scenarios pinned by hand-computed cycle numbers.
module tb_sr_ff_drive_ctrl;
  localparam int P = 2;
  localparam int T = 8;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_op = 1'b0;
  logic cmd_ready, S, R, busy, done, err;
  logic [7:0] err_cnt;
  logic ff_q = 1'b0, rnd_q = 1'b0, stuck_q = 1'b0;
  logic [1:0] mode = 2'd0;
  logic q_fb;
  int vectors = 0, miscompares = 0;
  logic m_busy = 1'b0, m_op = 1'b0;
  logic e_s = 1'b0, e_r = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int m_k = 0, m_errs = 0;
  assign q_fb = mode == 2'd0 ? ff_q : mode == 2'd1 ? rnd_q : stuck_q;
  always #5 clk = ~clk;
  sr_ff_drive_ctrl #(.PULSE_CYC(P), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .q_fb(q_fb), .S(S), .R(R), .busy(busy),
    .done(done), .err(err), .err_cnt(err_cnt)
  );
  // Downstream clocked SR flip-flop (S has priority; S=R=1 never reaches it)
  always @(posedge clk) ff_q <= S ? 1'b1 : R ? 1'b0 : ff_q;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: times everything relative to the accept edge k=0.
  // Drive on cycles after edges 0..P-1, Q samples on edges P+1..P+T.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_k = 0; m_errs = 0;
      e_s = 1'b0; e_r = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_s = 1'b0; e_r = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1'b1; m_op = cmd_op; m_k = 0;
          e_s = cmd_op; e_r = !cmd_op;
        end
      end else begin
        m_k++;
        if (m_k < P) begin
          e_s = m_op; e_r = !m_op;
        end else if (m_k >= P + 1) begin
          if (q_fb == m_op) begin
            e_done = 1'b1; m_busy = 1'b0;
          end else if (m_k == P + T) begin
            e_err = 1'b1; m_busy = 1'b0;
            m_errs = m_errs == 255 ? 255 : m_errs + 1;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("S", 8'(S), 8'(e_s));
    chk("R", 8'(R), 8'(e_r));
    chk("S_and_R", 8'(S & R), 8'd0);
    chk("done", 8'(done), 8'(e_done));
    chk("err", 8'(err), 8'(e_err));
    chk("busy", 8'(busy), 8'(m_busy));
    chk("cmd_ready", 8'(cmd_ready), 8'(!m_busy));
    chk("err_cnt", err_cnt, 8'(m_errs));
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  initial begin
    int err_at, dones, n;
    logic seen;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_S", 8'(S), 8'd0);
    chk("rst_R", 8'(R), 8'd0);
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    // Set with the flip-flop connected: accept edge 0, done in cycle 4
    mode = 2'd0; cmd_op = 1'b1; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    chk("set_c1_S", 8'(S), 8'd1); chk("set_c1_R", 8'(R), 8'd0); chk("set_c1_busy", 8'(busy), 8'd1);
    tick();
    chk("set_c2_S", 8'(S), 8'd1); chk("set_c2_R", 8'(R), 8'd0);
    tick();
    chk("set_c3_S", 8'(S), 8'd0); chk("set_c3_done", 8'(done), 8'd0);
    tick();
    chk("set_c4_done", 8'(done), 8'd1); chk("set_c4_ready", 8'(cmd_ready), 8'd1); chk("set_c4_q", 8'(q_fb), 8'd1);
    // Back-to-back set then clear with cmd_valid held
    tick();
    cmd_op = 1'b1; cmd_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = done;
    end
    chk("b2b_first_done", 8'(seen), 8'd1);
    cmd_op = 1'b0;
    tick(); cmd_valid = 1'b0;
    chk("b2b_c1_R", 8'(R), 8'd1); chk("b2b_c1_S", 8'(S), 8'd0);
    tick();
    chk("b2b_c2_R", 8'(R), 8'd1);
    tick();
    chk("b2b_c3_R", 8'(R), 8'd0); chk("b2b_c3_done", 8'(done), 8'd0);
    tick();
    chk("b2b_c4_done", 8'(done), 8'd1); chk("b2b_c4_q", 8'(q_fb), 8'd0);
    // Q stuck at 0: err in cycle P+T+1 = 11
    tick();
    mode = 2'd2; stuck_q = 1'b0; cmd_op = 1'b1; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    err_at = 0; dones = 0;
    for (int c = 1; c <= 14; c++) begin
      if (err && err_at == 0) err_at = c;
      if (done) dones++;
      if (c < 14) tick();
    end
    chk("timeout_err_cycle", 8'(err_at), 8'd11);
    chk("timeout_no_done", 8'(dones), 8'd0);
    chk("timeout_err_cnt", err_cnt, 8'd1);
    // Reset during DRIVE drops S before the next edge
    mode = 2'd0;
    tick();
    cmd_op = 1'b1; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    chk("rd_c1_S", 8'(S), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("rd_async_S", 8'(S), 8'd0);
    chk("rd_async_busy", 8'(busy), 8'd0);
    chk("rd_async_ready", 8'(cmd_ready), 8'd1);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rd_no_done", 8'(done), 8'd0);
      chk("rd_no_err", 8'(err), 8'd0);
      chk("rd_idle", 8'(cmd_ready), 8'd1);
    end
    // Randomized traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      cmd_valid = $urandom_range(0, 3) != 0;
      cmd_op = 1'($urandom);
      rnd_q = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        mode = 2'($urandom_range(0, 2));
        stuck_q = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        rst_n = 1'b1;
      end
    end
    // Saturation: 257 forced timeouts
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 2'd2; stuck_q = 1'b0; cmd_op = 1'b1; cmd_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 4000 && n < 257; c++) begin
      tick();
      if (err) begin
        n++;
        if (n == 255) chk("sat_255", err_cnt, 8'd255);
        if (n == 256) chk("sat_256", err_cnt, 8'd255);
        if (n == 257) chk("sat_257", err_cnt, 8'd255);
      end
    end
    chk("sat_errs_seen", 8'(n == 257), 8'd1);
    cmd_valid = 1'b0;
    tick();
    chk("sat_hold", err_cnt, 8'd255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
